// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequential AES-128 key-schedule controller. A cipher key is accepted over a
//   valid/ready handshake, then one shared round datapath produces one round
//   key per cycle for NR cycles. Round keys 0..NR live in a register file that
//   the cipher core reads by round index through a registered read port.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous reset, active-high
//   key_valid  : cipher key offered
//   key        : cipher key, bits [127:96] = w0
//   key_ready  : controller can accept a key (IDLE or DONE)
//   busy       : expansion in progress
//   keys_valid : all round keys 0..NR for the current key are stored
//   done       : one-cycle pulse when expansion completes
//   rd_en      : round-key read request
//   rd_round   : round index to read
//   rd_data    : round key, registered
//   rd_vld     : rd_data valid, one cycle after an accepted rd_en
//   rd_err     : one-cycle pulse, slot not yet written or index > NR
//   zeroize    : (only with KEY_SCHED_ZEROIZE_EN) wipe storage, return to IDLE
//
// Build option
//   KEY_SCHED_ZEROIZE_EN : adds the zeroize input.

module aes_key_sched_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [KW-1:0] key,
    output logic          key_ready,
    output logic          busy,
    output logic          keys_valid,
    output logic          done,
    input  logic          rd_en,
    input  logic [3:0]    rd_round,
    output logic [KW-1:0] rd_data,
    output logic          rd_vld,
    output logic          rd_err
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    input  logic          zeroize
`endif
);

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    r_q;        // index of the slot written by the next EXPAND edge
    logic [3:0]    wc_q;       // highest slot written for the current key
    logic          have_q;     // a key has been loaded since reset/zeroize
    logic [KW-1:0] wk_q;       // working register feeding the round datapath
    logic [KW-1:0] slots [0:NR];
    logic [KW-1:0] rk_next;
    logic          load, step, last_step, zero, rd_ok;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-expansion round from the working register.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, tem, o0, o1, o2, o3;
        w0  = wk_q[127:96];
        w1  = wk_q[95:64];
        w2  = wk_q[63:32];
        w3  = wk_q[31:0];
        tem = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
        o0  = w0 ^ tem ^ {rcon(r_q), 24'h0};
        o1  = o0 ^ w1;
        o2  = o1 ^ w2;
        o3  = o2 ^ w3;
        rk_next = {o0, o1, o2, o3};
    end

    always_comb begin
        state_d   = state_q;
        key_ready = (state_q != EXPAND);
        busy      = (state_q == EXPAND);
        load      = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                load = key_valid;
                if (key_valid) state_d = EXPAND;
            end
            EXPAND: begin
                step = 1'b1;
                if (r_q == NR_L) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (zero) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Slot 0 is rejected on a load edge because it is being overwritten;
    // during EXPAND the slot being written is always above wc_q.
    assign rd_ok = rd_en && have_q && (rd_round <= NR_L) && (rd_round <= wc_q)
                   && !(load && (rd_round == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= 4'd0;
            wc_q       <= 4'd0;
            have_q     <= 1'b0;
            keys_valid <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= rd_ok;
            rd_err <= rd_en && !rd_ok;
            if (rd_ok) rd_data <= slots[rd_round];
            if (zero) begin
                wc_q       <= 4'd0;
                have_q     <= 1'b0;
                keys_valid <= 1'b0;
                rd_data    <= '0;
                rd_vld     <= 1'b0;
                rd_err     <= rd_en;
            end else if (load) begin
                r_q        <= 4'd1;
                wc_q       <= 4'd0;
                have_q     <= 1'b1;
                keys_valid <= 1'b0;
            end else if (step) begin
                wc_q <= r_q;
                r_q  <= r_q + 4'd1;
                if (last_step) begin
                    keys_valid <= 1'b1;
                    done       <= 1'b1;
                end
            end
        end
    end

    // Storage is deliberately not reset; validity is tracked by have_q/wc_q.
    always_ff @(posedge clk) begin
        if (zero) begin
            for (int unsigned i = 0; i <= NR; i++) slots[i] <= '0;
            wk_q <= '0;
        end else if (load) begin
            slots[0] <= key;
            wk_q     <= key;
        end else if (step) begin
            slots[r_q] <= rk_next;
            wk_q       <= rk_next;
        end
    end

endmodule
